// File: rtl/iiitb_cg_ctrl_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | iiitb_cg_ctrl_if : upstream handshake / ICG enable bundle  Rev 1.0 |
// +------------------------------------------------------------------+
interface iiitb_cg_ctrl_if;
  logic        req;
  logic        force_on;
  logic        cg_en;
  logic        ready;
  logic        gated;
  logic [15:0] gate_count;

  modport master (
    output req,
    output force_on,
    input  cg_en,
    input  ready,
    input  gated,
    input  gate_count
  );

  modport slave (
    input  req,
    input  force_on,
    output cg_en,
    output ready,
    output gated,
    output gate_count
  );
endinterface
`default_nettype wire

// File: rtl/iiitb_cg_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | iiitb_cg_ctrl : idle-timeout clock-gate enable controller  Rev 1.0 |
// +------------------------------------------------------------------+
module iiitb_cg_ctrl #(
  parameter int IDLE_CYCLES = 8,
  parameter int WAKE_CYCLES = 2,
  parameter int CNT_W       = 8
) (
  input  wire logic         clk,
  input  wire logic         rst,
  iiitb_cg_ctrl_if.slave    bus
);

  typedef enum logic [1:0] {
    ST_ACTIVE = 2'd0,
    ST_GATED  = 2'd1,
    ST_WAKE   = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] C_IDLE_LAST = CNT_W'(IDLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_WAKE_INIT = CNT_W'(WAKE_CYCLES - 1);
  localparam logic [15:0]      C_GC_MAX    = 16'hFFFF;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  idle_cnt_q, idle_cnt_d;
  logic [CNT_W-1:0]  wake_cnt_q, wake_cnt_d;
  logic [15:0]       gate_count_q, gate_count_d;
  logic              cg_en_q, cg_en_d;
  logic              ready_q, ready_d;
  logic              gated_q, gated_d;
  logic              act;

  assign act = bus.req | bus.force_on;

  always_comb begin
    state_d      = state_q;
    idle_cnt_d   = idle_cnt_q;
    wake_cnt_d   = wake_cnt_q;
    gate_count_d = gate_count_q;

    case (state_q)
      ST_ACTIVE: begin
        if (act) begin
          idle_cnt_d = '0;
        end else if (idle_cnt_q == C_IDLE_LAST) begin
          state_d    = ST_GATED;
          idle_cnt_d = '0;
          if (gate_count_q != C_GC_MAX) begin
            gate_count_d = gate_count_q + 16'd1;
          end
        end else begin
          idle_cnt_d = idle_cnt_q + CNT_W'(1);
        end
      end
      ST_GATED: begin
        if (act) begin
          state_d    = ST_WAKE;
          wake_cnt_d = C_WAKE_INIT;
        end
      end
      ST_WAKE: begin
        // Wake always runs to completion so the gated domain gets its full settle time.
        if (wake_cnt_q == '0) begin
          state_d    = ST_ACTIVE;
          idle_cnt_d = '0;
        end else begin
          wake_cnt_d = wake_cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_ACTIVE;
    endcase

    // Outputs are decoded from the next state so they register alongside it.
    cg_en_d = (state_d != ST_GATED);
    ready_d = (state_d == ST_ACTIVE);
    gated_d = (state_d == ST_GATED);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_ACTIVE;
      idle_cnt_q   <= '0;
      wake_cnt_q   <= '0;
      gate_count_q <= '0;
      cg_en_q      <= 1'b1;
      ready_q      <= 1'b1;
      gated_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      idle_cnt_q   <= idle_cnt_d;
      wake_cnt_q   <= wake_cnt_d;
      gate_count_q <= gate_count_d;
      cg_en_q      <= cg_en_d;
      ready_q      <= ready_d;
      gated_q      <= gated_d;
    end
  end

  assign bus.cg_en      = cg_en_q;
  assign bus.ready      = ready_q;
  assign bus.gated      = gated_q;
  assign bus.gate_count = gate_count_q;

endmodule
`default_nettype wire

// File: tb/tb_iiitb_cg_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_iiitb_cg_ctrl : directed bench for iiitb_cg_ctrl        Rev 1.0 |
// +------------------------------------------------------------------+
module tb_iiitb_cg_ctrl;

  logic clk = 1'b0;
  logic rst_m;
  logic rst_s;

  always #5 clk = ~clk;

  iiitb_cg_ctrl_if bus_m ();
  iiitb_cg_ctrl_if bus_s ();

  iiitb_cg_ctrl #(.IDLE_CYCLES(8), .WAKE_CYCLES(2), .CNT_W(8)) u_dut (
    .clk (clk),
    .rst (rst_m),
    .bus (bus_m.slave)
  );

  iiitb_cg_ctrl #(.IDLE_CYCLES(1), .WAKE_CYCLES(1), .CNT_W(8)) u_dut_sat (
    .clk (clk),
    .rst (rst_s),
    .bus (bus_s.slave)
  );

  typedef struct {
    string       tag;
    logic [18:0] exp;
  } item_t;

  item_t sb[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  // Expected word layout: {cg_en, ready, gated, gate_count}
  task automatic check_front(input logic [18:0] obs);
    item_t it;
    n_checks++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty: observed %h required an expected entry", obs);
    end else begin
      it = sb.pop_front();
      assert (obs === it.exp) else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h", it.tag, obs, it.exp);
      end
    end
  endtask

  task automatic step_m(input string tag, input logic cg, input logic rdy,
                        input logic gtd, input logic [15:0] gc);
    sb.push_back('{tag, {cg, rdy, gtd, gc}});
    @(posedge clk);
    #1;
    check_front({bus_m.cg_en, bus_m.ready, bus_m.gated, bus_m.gate_count});
  endtask

  task automatic step_s(input string tag, input logic cg, input logic rdy,
                        input logic gtd, input logic [15:0] gc);
    sb.push_back('{tag, {cg, rdy, gtd, gc}});
    @(posedge clk);
    #1;
    check_front({bus_s.cg_en, bus_s.ready, bus_s.gated, bus_s.gate_count});
  endtask

  initial begin
    logic [15:0] gc;
    rst_m          = 1'b1;
    rst_s          = 1'b1;
    bus_m.req      = 1'b0;
    bus_m.force_on = 1'b0;
    bus_s.req      = 1'b0;
    bus_s.force_on = 1'b0;

    step_m("reset_1", 1, 1, 0, 16'd0);
    step_m("reset_2", 1, 1, 0, 16'd0);
    rst_m = 1'b0;

    // Idle window: seven edges stay active, the eighth gates.
    for (int i = 0; i < 7; i++) step_m("idle_active", 1, 1, 0, 16'd0);
    step_m("idle_gate", 0, 0, 1, 16'd1);
    step_m("gated_hold", 0, 0, 1, 16'd1);

    // Wake handshake with req held until the transfer.
    bus_m.req = 1'b1;
    step_m("wake_k", 1, 0, 0, 16'd1);
    step_m("wake_k1", 1, 0, 0, 16'd1);
    step_m("wake_k2_ready", 1, 1, 0, 16'd1);
    step_m("transfer_k3", 1, 1, 0, 16'd1);
    bus_m.req = 1'b0;

    // Idle window restart, including act on the would-be gating edge.
    for (int i = 0; i < 7; i++) step_m("restart_low_a", 1, 1, 0, 16'd1);
    bus_m.req = 1'b1;
    step_m("restart_boundary", 1, 1, 0, 16'd1);
    bus_m.req = 1'b0;
    for (int i = 0; i < 7; i++) step_m("restart_low_b", 1, 1, 0, 16'd1);
    step_m("restart_gate", 0, 0, 1, 16'd2);

    // force_on pulse from GATED runs a full wake.
    bus_m.force_on = 1'b1;
    step_m("force_wake_k", 1, 0, 0, 16'd2);
    bus_m.force_on = 1'b0;
    step_m("force_wake_k1", 1, 0, 0, 16'd2);
    step_m("force_active", 1, 1, 0, 16'd2);

    // force_on held keeps the clock on.
    bus_m.force_on = 1'b1;
    for (int i = 0; i < 50; i++) step_m("force_hold", 1, 1, 0, 16'd2);
    bus_m.force_on = 1'b0;

    // Reset during WAKE, with req high.
    for (int i = 0; i < 7; i++) step_m("pre_wake_idle", 1, 1, 0, 16'd2);
    step_m("pre_wake_gate", 0, 0, 1, 16'd3);
    bus_m.req = 1'b1;
    step_m("pre_wake_enter", 1, 0, 0, 16'd3);
    rst_m = 1'b1;
    step_m("rst_in_wake", 1, 1, 0, 16'd0);
    rst_m     = 1'b0;
    bus_m.req = 1'b0;

    // Reset during GATED, with force_on high; idle counter must restart too.
    for (int i = 0; i < 7; i++) step_m("post_rst_idle", 1, 1, 0, 16'd0);
    step_m("post_rst_gate", 0, 0, 1, 16'd1);
    rst_m          = 1'b1;
    bus_m.force_on = 1'b1;
    step_m("rst_in_gated", 1, 1, 0, 16'd0);
    rst_m = 1'b0;
    step_m("rst_release_forced", 1, 1, 0, 16'd0);
    bus_m.force_on = 1'b0;

    // Saturation with IDLE_CYCLES=1, WAKE_CYCLES=1.
    step_s("sat_reset", 1, 1, 0, 16'd0);
    rst_s = 1'b0;
    for (int i = 1; i <= 65540; i++) begin
      gc = (i > 65535) ? 16'hFFFF : 16'(i);
      bus_s.req = 1'b0;
      step_s("sat_gate", 0, 0, 1, gc);
      bus_s.req = 1'b1;
      step_s("sat_wake", 1, 0, 0, gc);
      bus_s.req = 1'b0;
      step_s("sat_active", 1, 1, 0, gc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/iiitb_cg_ctrl.md
# iiitb_cg_ctrl

Clock-gating enable controller. It drives the enable input of the team's latch-based integrated clock gate (ICG) cell. It watches upstream request activity and deasserts the gate enable after a programmable idle period. On new activity it re-enables the clock and holds off the upstream with a `ready` handshake until the gated domain has had a programmable number of wake-up cycles. It sits in the free-running `clk` domain, in front of the ICG and the registers that the ICG clocks.

## Interface
Parameters:
- `IDLE_CYCLES`, default 8: consecutive idle samples before gating; legal range 1 to 2^`CNT_W`−1.
- `WAKE_CYCLES`, default 2: cycles from enable reassertion to `ready`; minimum 1.
- `CNT_W`, default 8: width of the idle and wake counters.

Ports:
- `clk`, input, 1: free-running clock; all state is updated on its rising edge.
- `rst`, input, 1: reset, synchronous and active-high.
- `req`, input, 1: upstream has work for the gated domain.
- `force_on`, input, 1: debug/override; keeps the clock enabled.
- `cg_en`, output, 1: registered enable to the ICG enable input.
- `ready`, output, 1: upstream may transfer; a transfer is `req && ready` at a rising edge.
- `gated`, output, 1: status; 1 while in GATED.
- `gate_count`, output, 16: number of gating events, saturating.

## Operation
- There are three states: ACTIVE, GATED, WAKE. All outputs are registered and are pure functions of the state.
  - ACTIVE: `cg_en`=1, `ready`=1, `gated`=0.
  - GATED: `cg_en`=0, `ready`=0, `gated`=1.
  - WAKE: `cg_en`=1, `ready`=0, `gated`=0.
- Reset values: state ACTIVE, `cg_en`=1, `ready`=1, `gated`=0, idle counter 0, wake counter 0, `gate_count`=0.
- Define `act` = `req | force_on`.
- ACTIVE:
  - If `act`=1: idle counter ← 0.
  - Else if idle counter == `IDLE_CYCLES`−1: go to GATED, clear the idle counter, and increment `gate_count`.
  - Else: idle counter += 1.
- GATED: if `act`=1, go to WAKE with wake counter ← `WAKE_CYCLES`−1. Otherwise hold.
- WAKE:
  - If wake counter == 0: go to ACTIVE with idle counter ← 0.
  - Else: wake counter −= 1.
  - WAKE is never aborted. Dropping `req` or `force_on` during WAKE does not return to GATED.
- `gate_count` saturates at 0xFFFF and never wraps.

## Timing
- Gating latency: `req`/`force_on` sampled low on `IDLE_CYCLES` consecutive ACTIVE edges. `cg_en` falls immediately after the last of those edges.
- Any `act`=1 sample in ACTIVE restarts the idle window from zero.
- Wake latency: `act` is sampled high in GATED at edge k.
  - `cg_en`=1 after edge k.
  - `ready`=1 after edge k+`WAKE_CYCLES`.
- Returning to GATED after a wake needs at least `IDLE_CYCLES` further idle samples in ACTIVE.
- `cg_en` changes only right after a `clk` rising edge, so it is glitch-free at the ICG. The ICG latch transparency adds its own half-cycle alignment downstream; this block does not account for it.
- `ready` never rises in the same cycle as `cg_en`. The gated domain always sees at least `WAKE_CYCLES` clock edges before the first transfer.
- Upstream handshake: `req` must be held until it is sampled with `ready`=1. The controller never drops `ready` while in ACTIVE with `act`=1.
- Boundaries:
  - `IDLE_CYCLES`=1: gates after a single idle sample.
  - `WAKE_CYCLES`=1: WAKE lasts exactly one cycle.
  - `act` rising on the same edge where the idle counter hits `IDLE_CYCLES`−1: stay in ACTIVE, counter ← 0.
  - `rst` asserted mid-operation in any state: on the next edge, all reset values are restored, and `rst` dominates `req`/`force_on`.

## Test plan
- Reset then idle: `rst` for 2 cycles, then `req`=0 (defaults 8/2).
  - During reset: `cg_en`=1, `ready`=1, `gate_count`=0.
  - `cg_en`=0 and `gated`=1 after the 8th idle edge.
  - `gate_count`=1.
- Wake handshake: from GATED, `req`=1 at edge k.
  - `cg_en`=1 after k.
  - `ready`=0 after k and k+1; `ready`=1 after k+2.
  - The transfer completes at k+3.
- Idle-window restart: `req` low 7 edges, high 1 edge, low 7 edges → `cg_en` stays 1 throughout; 1 more idle edge → gates.
- `force_on`: held at 1 with `req`=0 for 50 cycles → never gated, `gate_count` unchanged. From GATED, `force_on` pulse for 1 cycle → full WAKE, then ACTIVE.
- Mid-operation reset: `rst` asserted in WAKE and in GATED → next edge in ACTIVE, `cg_en`=1, `ready`=1, `gate_count`=0.
- Saturation (`IDLE_CYCLES`=1, `WAKE_CYCLES`=1): toggle `req` to force 65,540 gate events → `gate_count` stays at 0xFFFF.
